// File: rtl/ivector_pkg.sv
// ivector_pkg: shared arbitration modes and channel-index width helper for the heard path.
package ivector_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ivector_fifo.sv
// ivector_fifo: single-clock FIFO with registered count; no bypass, head visible one cycle after enq.
module ivector_fifo #(
  parameter int WIDTH = 704,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_v,
  output logic             notFull,
  input  logic             deq,
  output logic [WIDTH-1:0] first,
  output logic             notEmpty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push, pop;

  always_comb begin
    notFull  = cnt_q != (AW+1)'(DEPTH);
    notEmpty = cnt_q != '0;
    push     = enq & notFull;
    pop      = deq & notEmpty;
    wp_d     = push ? wp_q + AW'(1) : wp_q;
    rp_d     = pop ? rp_q + AW'(1) : rp_q;
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    first    = mem_q[rp_q];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; the cleared count makes stale entries unreachable.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wp_q] <= enq_v;
  end

endmodule

// File: rtl/ivector_mux.sv
// ivector_mux: per-channel say FIFOs arbitrated onto one rule-gated heard indication.
module ivector_mux
  import ivector_pkg::*;
#(
  parameter int  WIDTH    = 704,
  parameter int  DEPTH    = 4,
  parameter int  NCHAN    = 4,
  parameter int  ARB_MODE = ARB_RR,
  localparam int CW       = chan_width(NCHAN)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NCHAN-1:0]       say__ENA,
  input  logic [NCHAN*WIDTH-1:0] say_v,
  output logic [NCHAN-1:0]       say__RDY,
  output logic                   ind_heard__ENA,
  output logic [WIDTH-1:0]       ind_heard_heard_v,
  output logic [CW-1:0]          ind_heard_chan,
  input  logic                   ind_heard__RDY,
  output logic [31:0]            heard_count,
  input  logic                   rule_enable,
  output logic                   rule_ready
);

  logic [NCHAN-1:0] valid, deq;
  logic [WIDTH-1:0] head [NCHAN];
  logic [CW-1:0]    last_q, last_d, grant;
  logic [31:0]      count_q, count_d;
  logic             fire;

  // Scan from lowest to highest priority so the last hit is the winner.
  function automatic logic [CW-1:0] arbitrate(input logic [NCHAN-1:0] v, input logic [CW-1:0] last);
    logic [CW-1:0] g;
    int idx;
    g = '0;
    for (int k = NCHAN; k >= 1; k--) begin
      idx = (ARB_MODE == ARB_FIXED) ? k - 1 : (int'(last) + k) % NCHAN;
      if (v[idx]) g = CW'(idx);
    end
    return g;
  endfunction

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    ivector_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .CLK      (CLK),
      .RST      (RST),
      .enq      (say__ENA[c]),
      .enq_v    (say_v[c*WIDTH +: WIDTH]),
      .notFull  (say__RDY[c]),
      .deq      (deq[c]),
      .first    (head[c]),
      .notEmpty (valid[c])
    );
    assign deq[c] = fire && (grant == CW'(c));
  end

  always_comb begin
    grant             = arbitrate(valid, last_q);
    rule_ready        = (|valid) & ind_heard__RDY;
    fire              = rule_enable & rule_ready;
    last_d            = (fire && ARB_MODE == ARB_RR) ? grant : last_q;
    count_d           = fire ? count_q + 32'd1 : count_q;
    ind_heard__ENA    = fire;
    ind_heard_chan    = (|valid) ? grant : '0;
    ind_heard_heard_v = (|valid) ? head[grant] : '0;
    heard_count       = count_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_q  <= CW'(NCHAN - 1);
      count_q <= '0;
    end else begin
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

endmodule
